// File: rtl/ring_round_ctrl.sv
// rtl/ring_round_ctrl.sv - head/tail pointer, wrap and occupancy controller for a circular buffer
// Sits between the MAC input-buffer writer (rec_*) and the MAC read/issue logic (send_*).
module ring_round_ctrl #(
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             rec_req,
  output logic             rec_ack,
  input  logic             send_req,
  output logic             send_ack,
  output logic [PTR_W-1:0] tp,
  output logic [PTR_W-1:0] hp,
  output logic             round,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow,
  input  logic             err_clr
);

  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic t_wrap;
  logic h_wrap;

  // Status comes only from registered state so req inputs never reach the flags.
  assign full         = (count == FULL_CNT);
  assign empty        = (count == '0);
  assign round        = t_wrap ^ h_wrap;
  assign almost_full  = (int'(count) >= AF_LEVEL);
  assign almost_empty = (int'(count) <= AE_LEVEL);

  assign rec_ack  = rec_req  && !full  && !flush;
  assign send_ack = send_req && !empty && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tp     <= '0;
      hp     <= '0;
      t_wrap <= 1'b0;
      h_wrap <= 1'b0;
      count  <= '0;
    end else if (flush) begin
      tp     <= '0;
      hp     <= '0;
      t_wrap <= 1'b0;
      h_wrap <= 1'b0;
      count  <= '0;
    end else begin
      if (rec_ack) begin
        if (tp == LAST_IDX) begin
          tp     <= '0;
          t_wrap <= ~t_wrap;
        end else begin
          tp <= tp + PTR_W'(1);
        end
      end
      if (send_ack) begin
        if (hp == LAST_IDX) begin
          hp     <= '0;
          h_wrap <= ~h_wrap;
        end else begin
          hp <= hp + PTR_W'(1);
        end
      end
      // Simultaneous accept leaves occupancy unchanged.
      if (rec_ack && !send_ack) begin
        count <= count + CNT_W'(1);
      end else if (send_ack && !rec_ack) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Error flags survive flush; only reset or err_clr clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (err_clr) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (rec_req && full) begin
        overflow <= 1'b1;
      end
      if (send_req && empty) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ring_round_ctrl.sv
// tb/tb_ring_round_ctrl.sv - self-checking bench for ring_round_ctrl (DEPTH=4 and DEPTH=5 instances)
module tb_ring_round_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic fl [2];
  logic wr [2];
  logic rd [2];
  logic ec [2];

  logic       ra0, sa0, rnd0, f0, e0, af0, ae0, ov0, un0;
  logic [1:0] tp0, hp0;
  logic [2:0] cnt0;
  logic       ra1, sa1, rnd1, f1, e1, af1, ae1, ov1, un1;
  logic [2:0] tp1, hp1;
  logic [2:0] cnt1;

  ring_round_ctrl #(.DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1)) u_d4 (
    .clk(clk), .rst_n(rst_n), .flush(fl[0]),
    .rec_req(wr[0]), .rec_ack(ra0), .send_req(rd[0]), .send_ack(sa0),
    .tp(tp0), .hp(hp0), .round(rnd0), .count(cnt0),
    .full(f0), .empty(e0), .almost_full(af0), .almost_empty(ae0),
    .overflow(ov0), .underflow(un0), .err_clr(ec[0])
  );

  ring_round_ctrl #(.DEPTH(5)) u_d5 (
    .clk(clk), .rst_n(rst_n), .flush(fl[1]),
    .rec_req(wr[1]), .rec_ack(ra1), .send_req(rd[1]), .send_ack(sa1),
    .tp(tp1), .hp(hp1), .round(rnd1), .count(cnt1),
    .full(f1), .empty(e1), .almost_full(af1), .almost_empty(ae1),
    .overflow(ov1), .underflow(un1), .err_clr(ec[1])
  );

  // Reference: total writes/reads since the last reset or flush; everything else follows arithmetically.
  int depth [2] = '{4, 5};
  int af_l  [2] = '{3, 4};
  int ae_l  [2] = '{1, 1};
  int mw    [2];
  int mr    [2];
  bit mov   [2];
  bit mun   [2];
  int tests = 0;
  int fails = 0;

  function automatic int mcount(int d);
    return mw[d] - mr[d];
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mw[d] = 0; mr[d] = 0; mov[d] = 1'b0; mun[d] = 1'b0;
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_state(int d, string tag);
    int c;
    int dp;
    c  = mcount(d);
    dp = depth[d];
    chk({tag, " tp"},    d ? 32'(tp1)  : 32'(tp0),  32'(mw[d] % dp));
    chk({tag, " hp"},    d ? 32'(hp1)  : 32'(hp0),  32'(mr[d] % dp));
    chk({tag, " round"}, d ? 32'(rnd1) : 32'(rnd0), 32'(((mw[d] / dp) + (mr[d] / dp)) % 2));
    chk({tag, " count"}, d ? 32'(cnt1) : 32'(cnt0), 32'(c));
    chk({tag, " full"},  d ? 32'(f1)   : 32'(f0),   32'(c == dp));
    chk({tag, " empty"}, d ? 32'(e1)   : 32'(e0),   32'(c == 0));
    chk({tag, " almost_full"},  d ? 32'(af1) : 32'(af0), 32'(c >= af_l[d]));
    chk({tag, " almost_empty"}, d ? 32'(ae1) : 32'(ae0), 32'(c <= ae_l[d]));
    chk({tag, " overflow"},  d ? 32'(ov1) : 32'(ov0), 32'(mov[d]));
    chk({tag, " underflow"}, d ? 32'(un1) : 32'(un0), 32'(mun[d]));
  endtask

  // One clock of stimulus on instance d; starts and ends 1 time unit after a rising edge.
  task automatic step(int d, bit w, bit r, bit f, bit e, string tag);
    int c;
    int dp;
    wr[d] = w; rd[d] = r; fl[d] = f; ec[d] = e;
    #1;
    c  = mcount(d);
    dp = depth[d];
    chk({tag, " rec_ack"},  d ? 32'(ra1) : 32'(ra0), 32'(w && !f && c < dp));
    chk({tag, " send_ack"}, d ? 32'(sa1) : 32'(sa0), 32'(r && !f && c > 0));
    @(posedge clk);
    if (e) begin
      mov[d] = 1'b0; mun[d] = 1'b0;
    end else begin
      if (w && c == dp) mov[d] = 1'b1;
      if (r && c == 0)  mun[d] = 1'b1;
    end
    if (f) begin
      mw[d] = 0; mr[d] = 0;
    end else begin
      if (w && c < dp) mw[d]++;
      if (r && c > 0)  mr[d]++;
    end
    #1;
    chk_state(d, tag);
    wr[d] = 1'b0; rd[d] = 1'b0; fl[d] = 1'b0; ec[d] = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      wr[d] = 1'b0; rd[d] = 1'b0; fl[d] = 1'b0; ec[d] = 1'b0;
    end
    model_reset();
    #12;
    chk_state(0, "reset d4");
    chk_state(1, "reset d5");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill DEPTH=4, then one refused write sets overflow.
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, "fill");
    step(0, 1, 0, 0, 0, "write_when_full");
    // Drain, then one refused read sets underflow; err_clr clears both.
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, "drain");
    step(0, 0, 1, 0, 0, "read_when_empty");
    step(0, 0, 0, 0, 1, "err_clr");

    // DEPTH=5: alternating write/read pairs across the pointer wrap.
    for (int i = 0; i < 7; i++) begin
      step(1, 1, 0, 0, 0, "d5_pair_wr");
      step(1, 0, 1, 0, 0, "d5_pair_rd");
    end

    // Simultaneous requests when full, then at count 2.
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, "refill");
    step(0, 1, 1, 0, 0, "both_when_full");
    step(0, 0, 1, 0, 0, "to_two");
    step(0, 1, 1, 0, 0, "both_at_two");
    step(0, 0, 0, 0, 1, "clear_ovf");

    // Thresholds walked up by single writes, then flush at count 3 alongside rec_req.
    step(0, 1, 0, 0, 0, "af_at_3");
    step(0, 0, 1, 0, 0, "ae_back_2");
    step(0, 1, 0, 0, 0, "count_3");
    step(0, 1, 0, 1, 0, "flush_with_req");

    // Randomised traffic on both instances.
    for (int i = 0; i < 400; i++) begin
      step(i % 2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 15) == 0), "rnd");
    end

    // Async reset mid-stream, held across an edge while a write is requested.
    step(0, 1, 0, 0, 0, "pre_rst");
    step(0, 1, 0, 0, 0, "pre_rst");
    step(1, 1, 0, 0, 0, "pre_rst");
    #2;
    wr[0] = 1'b1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_state(0, "async_rst d4");
    chk_state(1, "async_rst d5");
    @(posedge clk);
    #1;
    chk_state(0, "write_in_reset");
    wr[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(0, 1, 0, 0, 0, "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
